// File: rtl/fp_div_sched_if.sv
// Bundle of the requester, divider and response signals of fp_div_sched.
// The scheduler uses the slave view; the surrounding logic uses the master view.
interface fp_div_sched_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_opA;
    logic [16*NUM_REQ-1:0] req_opB;
    logic [15:0]           div_opA;
    logic [15:0]           div_opB;
    logic [15:0]           div_quotient;
    logic [2:0]            div_flags;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [15:0]           resp_quotient;
    logic [2:0]            resp_flags;
    logic                  busy;

    modport slave (
        input  req_valid, req_opA, req_opB, div_quotient, div_flags, resp_ready,
        output req_ready, div_opA, div_opB, resp_valid, resp_id, resp_quotient, resp_flags,
               busy
    );

    modport master (
        output req_valid, req_opA, req_opB, div_quotient, div_flags, resp_ready,
        input  req_ready, div_opA, div_opB, resp_valid, resp_id, resp_quotient, resp_flags,
               busy
    );
endinterface

// File: rtl/fp_div_sched.sv
// Shares one pipelined bfloat16 divider between NUM_REQ requesters: round-robin grant,
// credit-limited issue, tag pipeline aligned to the divider, in-order result FIFO.
module fp_div_sched #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DIV_LAT    = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input logic           clk,
    input logic           reset_n,
    fp_div_sched_if.slave bus
);
    localparam int unsigned PTRW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNTW   = $clog2(FIFO_DEPTH + 1);
    // Stage 0 lines up with the operand register, the last stage with the quotient.
    localparam int unsigned STAGES = DIV_LAT + 1;
    localparam logic [CNTW:0] DepthW = (CNTW + 1)'(FIFO_DEPTH);

    logic [CNTW-1:0]  count_q, count_d;
    logic [CNTW-1:0]  inflight_q, inflight_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [15:0]      opa_q, opb_q;
    logic [STAGES-1:0] tag_vld_q;
    logic [IDW-1:0]   tag_id_q [STAGES];
    logic [IDW-1:0]   id_mem  [FIFO_DEPTH];
    logic [15:0]      quo_mem [FIFO_DEPTH];
    logic [2:0]       flg_mem [FIFO_DEPTH];
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;

    logic [CNTW:0]        used;
    logic                 credit_ok;
    logic [NUM_REQ-1:0]   grant;
    logic [IDW-1:0]       grant_id;
    logic                 hs;
    logic                 cap;
    logic                 pop;
    logic                 resp_vld;

    assign used      = {1'b0, count_q} + {1'b0, inflight_q};
    assign credit_ok = used < DepthW;
    assign cap       = tag_vld_q[STAGES-1];
    assign resp_vld  = count_q != '0;
    assign pop       = resp_vld && bus.resp_ready;

    // Reset gates the grant so req_ready drops as soon as reset_n falls.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        hs       = 1'b0;
        if (reset_n && credit_ok) begin
            for (int k = 0; k < int'(NUM_REQ); k++) begin
                if (!hs && bus.req_valid[(int'(rr_q) + k) % int'(NUM_REQ)]) begin
                    hs       = 1'b1;
                    grant_id = IDW'((int'(rr_q) + k) % int'(NUM_REQ));
                end
            end
        end
        if (hs) begin
            grant[grant_id] = 1'b1;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (hs) begin
            rr_d = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
        inflight_d = inflight_q + CNTW'(hs) - CNTW'(cap);
        count_d    = count_q + CNTW'(cap) - CNTW'(pop);
        wr_ptr_d   = wr_ptr_q;
        if (cap) begin
            wr_ptr_d = (wr_ptr_q == PTRW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTRW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q       <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
        end else begin
            rr_q       <= rr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (hs) begin
                opa_q <= bus.req_opA[16*grant_id +: 16];
                opb_q <= bus.req_opB[16*grant_id +: 16];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_vld_q <= '0;
            for (int s = 0; s < int'(STAGES); s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            tag_vld_q[0] <= hs;
            tag_id_q[0]  <= grant_id;
            for (int s = 1; s < int'(STAGES); s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                id_mem[i]  <= '0;
                quo_mem[i] <= '0;
                flg_mem[i] <= '0;
            end
        end else if (cap) begin
            id_mem[wr_ptr_q]  <= tag_id_q[STAGES-1];
            quo_mem[wr_ptr_q] <= bus.div_quotient;
            flg_mem[wr_ptr_q] <= bus.div_flags;
        end
    end

    assign bus.req_ready     = grant;
    assign bus.div_opA       = opa_q;
    assign bus.div_opB       = opb_q;
    assign bus.resp_valid    = resp_vld;
    assign bus.resp_id       = resp_vld ? id_mem[rd_ptr_q] : '0;
    assign bus.resp_quotient = resp_vld ? quo_mem[rd_ptr_q] : '0;
    assign bus.resp_flags    = resp_vld ? flg_mem[rd_ptr_q] : '0;
    assign bus.busy          = (count_q != '0) || (inflight_q != '0);

    a_count_range: assert property (@(posedge clk) disable iff (!reset_n)
        {1'b0, count_q} <= DepthW);
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(cap && !pop && ({1'b0, count_q} == DepthW)));
endmodule

// File: tb/tb_fp_div_sched.sv
// Bench for fp_div_sched: queue-based scoreboard checked every cycle, directed scenarios
// with literal expectations, a random phase, and a second DUT with a one-entry FIFO.
module tb_fp_div_sched;
    localparam int unsigned N     = 4;
    localparam int unsigned LAT   = 1;
    localparam int unsigned DEPTH = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fp_div_sched_if #(.NUM_REQ(N)) bus ();
    fp_div_sched_if #(.NUM_REQ(N)) bus1 ();

    fp_div_sched #(.NUM_REQ(N), .DIV_LAT(LAT), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    fp_div_sched #(.NUM_REQ(N), .DIV_LAT(LAT), .FIFO_DEPTH(1)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Truncating bfloat16 divide of normalised operands; returns {uf, of, ix, quotient}.
    function automatic logic [18:0] bf16_div(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        int          e;
        int unsigned ma, mb, n, r;
        logic        uf, of, ix;
        logic [15:0] q;
        s  = a[15] ^ b[15];
        ma = 32'h80 | 32'(a[6:0]);
        mb = 32'h80 | 32'(b[6:0]);
        e  = int'(a[14:7]) - int'(b[14:7]) + 127;
        n  = (ma << 8) / mb;
        r  = (ma << 8) % mb;
        if (n < 256) begin
            n = (ma << 9) / mb;
            r = (ma << 9) % mb;
            e = e - 1;
        end
        ix = (r != 0) || ((n & 1) != 0);
        uf = e <= 0;
        of = e >= 255;
        if (uf)      q = {s, 15'd0};
        else if (of) q = {s, 8'hFF, 7'd0};
        else         q = {s, e[7:0], n[7:1]};
        return {uf, of, ix, q};
    endfunction

    // Divider stand-ins, one register stage each
    always @(posedge clk) {bus.div_flags, bus.div_quotient} <= bf16_div(bus.div_opA, bus.div_opB);
    always @(posedge clk) {bus1.div_flags, bus1.div_quotient} <= bf16_div(bus1.div_opA, bus1.div_opB);

    typedef struct {
        int          id;
        logic [18:0] res;
        int          due;
    } ent_t;

    ent_t        pend[$];
    ent_t        fifo[$];
    int          glog[$];
    int          rr      = 0;
    int          cyc     = 0;
    int          nresp   = 0;
    int          credit;
    int          g;
    logic [15:0] last_a  = '0;
    logic [15:0] last_b  = '0;
    logic [15:0] opa, opb;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            pend.delete();
            fifo.delete();
            rr     = 0;
            last_a = '0;
            last_b = '0;
            glog.push_back(-1);
            check("reset_outputs", {bus.req_ready, bus.div_opA, bus.div_opB, bus.resp_valid,
                  bus.resp_id, bus.resp_flags, bus.resp_quotient, bus.busy}, '0);
        end else begin
            while (pend.size() > 0 && pend[0].due <= cyc) fifo.push_back(pend.pop_front());
            credit = int'(DEPTH) - fifo.size() - pend.size();
            g = -1;
            if (credit > 0) begin
                for (int k = 0; k < int'(N); k++) begin
                    if (g < 0 && bus.req_valid[(rr + k) % int'(N)]) g = (rr + k) % int'(N);
                end
            end
            check("req_ready", bus.req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
            check("div_ops", {bus.div_opA, bus.div_opB}, {last_a, last_b});
            if (fifo.size() > 0)
                check("resp", {bus.resp_valid, bus.resp_id, bus.resp_flags, bus.resp_quotient},
                      {1'b1, 2'(fifo[0].id), fifo[0].res});
            else
                check("resp_idle", {bus.resp_valid, bus.resp_id, bus.resp_flags,
                      bus.resp_quotient}, '0);
            check("busy", bus.busy, (pend.size() + fifo.size()) != 0);
            if (bus.resp_valid && bus.resp_ready) nresp++;
            glog.push_back(g);
            if (g >= 0) begin
                opa = bus.req_opA[16*g +: 16];
                opb = bus.req_opB[16*g +: 16];
                pend.push_back('{g, bf16_div(opa, opb), cyc + int'(LAT) + 2});
                last_a = opa;
                last_b = opb;
                rr     = (g + 1) % int'(N);
            end
            if (fifo.size() > 0 && bus.resp_ready) void'(fifo.pop_front());
        end
    end

    // One-entry FIFO instance: all requesters always valid
    int rr1   = 0;
    int cyc1  = 0;
    int last1 = -1;
    int n6    = 0;
    int ids1[$];

    always @(negedge clk) begin
        cyc1++;
        if (!reset_n) begin
            rr1   = 0;
            last1 = -1;
            ids1.delete();
        end else begin
            if (bus1.req_ready != '0) begin
                check("t6_grant", bus1.req_ready, 64'd1 << rr1);
                if (last1 >= 0) check("t6_gap", (cyc1 - last1) >= 3, 1);
                ids1.push_back(rr1);
                rr1   = (rr1 + 1) % int'(N);
                last1 = cyc1;
                n6++;
            end
            if (bus1.resp_valid && bus1.resp_ready) begin
                if (ids1.size() == 0) check("t6_resp_extra", bus1.resp_valid, 0);
                else check("t6_id", bus1.resp_id, ids1.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    int mark;
    int cnt;

    initial begin
        bus.req_valid   = '0;
        bus.req_opA     = '0;
        bus.req_opB     = '0;
        bus.resp_ready  = 1'b0;
        bus1.req_valid  = '1;
        bus1.req_opA    = {$urandom, $urandom};
        bus1.req_opB    = {$urandom, $urandom};
        bus1.resp_ready = 1'b1;
        repeat (3) step();
        reset_n = 1'b1;

        // Single divide 3.0 / 1.5
        bus.req_valid      = 4'b0001;
        bus.req_opA[15:0]  = 16'h4040;
        bus.req_opB[15:0]  = 16'h3FC0;
        bus.resp_ready     = 1'b1;
        step();
        bus.req_valid = '0;
        step();
        check("t1_not_early", bus.resp_valid, 0);
        step();
        check("t1_resp", {bus.resp_valid, bus.resp_id, bus.resp_quotient, bus.resp_flags},
              {1'b1, 2'd0, 16'h4000, 3'b000});
        step();
        check("t1_busy", bus.busy, 0);

        // Back-to-back round robin
        do_reset();
        mark = glog.size();
        bus.req_valid = '1;
        bus.req_opA   = {$urandom, $urandom};
        bus.req_opB   = {$urandom, $urandom};
        repeat (8) step();
        bus.req_valid = '0;
        for (int i = 0; i < 6; i++) check("t2_order", glog[mark+i], i % 4);
        repeat (6) step();

        // Backpressure fills the credits
        do_reset();
        bus.resp_ready = 1'b0;
        bus.req_valid  = '1;
        mark = glog.size();
        repeat (10) step();
        cnt = 0;
        for (int i = mark; i < glog.size(); i++) if (glog[i] >= 0) cnt++;
        check("t3_issued", cnt, 4);
        check("t3_stalled", bus.req_ready, 0);
        bus.resp_ready = 1'b1;
        mark = glog.size();
        repeat (10) step();
        cnt = 0;
        for (int i = mark; i < glog.size(); i++) if (glog[i] >= 0) cnt++;
        check("t3_resume", cnt >= 4, 1);
        bus.req_valid = '0;
        repeat (6) step();

        // Pointer moves past the last grant
        do_reset();
        mark = glog.size();
        bus.req_valid = 4'b0100;
        step();
        bus.req_valid = 4'b1001;
        repeat (3) step();
        bus.req_valid = '0;
        check("t4_first", glog[mark], 2);
        check("t4_second", glog[mark+1], 3);
        check("t4_third", glog[mark+2], 0);
        repeat (6) step();

        // Reset with work in flight
        do_reset();
        bus.resp_ready = 1'b0;
        bus.req_opA    = {4{16'h4123}};
        bus.req_opB    = {4{16'h3F80}};
        bus.req_valid  = '1;
        repeat (3) step();
        check("t5_pre_busy", {bus.busy, bus.resp_valid}, 2'b11);
        reset_n = 1'b0;
        #1;
        check("t5_async", {bus.req_ready, bus.div_opA, bus.div_opB, bus.resp_valid,
              bus.resp_id, bus.resp_flags, bus.resp_quotient, bus.busy}, '0);
        bus.req_valid = '0;
        step();
        reset_n        = 1'b1;
        bus.resp_ready = 1'b1;
        cnt = nresp;
        bus.req_valid = 4'b1000;
        step();
        bus.req_valid = '0;
        repeat (6) step();
        check("t5_one_resp", nresp - cnt, 1);

        // Random traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            bus.req_valid  = 4'($urandom_range(0, 15));
            bus.req_opA    = {$urandom, $urandom};
            bus.req_opB    = {$urandom, $urandom};
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            bus1.resp_ready = ($urandom_range(0, 1) != 0);
            step();
        end
        bus.req_valid   = '0;
        bus.resp_ready  = 1'b1;
        bus1.resp_ready = 1'b1;
        repeat (10) step();
        check("drain_busy", bus.busy, 0);
        check("t6_progress", n6 >= 50, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
